// File: rtl/hole_fill.sv
// Streaming hole filler: invalid disparities take the last valid value of the line, up to MAX_RUN.
// Optional per-line hole statistics on the hole_cnt port when HOLE_FILL_STATS_EN is defined.
module hole_fill #(
    parameter int unsigned       DWIDTH       = 16,
    parameter int unsigned       CWIDTH       = 11,
    parameter int unsigned       WIDTH        = 1920,
    parameter logic [DWIDTH-1:0] INVALID      = 16'hFFFF,
    parameter logic [DWIDTH-1:0] FILL_DEFAULT = 16'd0,
    parameter int unsigned       MAX_RUN      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              enable,
    input  logic [DWIDTH-1:0] din,
    input  logic              din_valid,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    output logic [CWIDTH-1:0] col,
    output logic              line_done
`ifdef HOLE_FILL_STATS_EN
    ,
    output logic [CWIDTH:0]   hole_cnt
`endif
);

    localparam int unsigned RW = $clog2(MAX_RUN + 1);
    localparam int unsigned HW = CWIDTH + 1;

    typedef enum logic [0:0] {StLead, StTrack} state_e;

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] last_q, last_d, fill;
    logic [RW-1:0]     run_q, run_d;
    logic [CWIDTH-1:0] cnt_q;
    logic              accept, is_inv, eol;

    assign accept = clken & enable & din_valid;
    assign is_inv = (din == INVALID);
    assign eol    = (cnt_q == CWIDTH'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLead;
        end else begin
            state_q <= state_d;
        end
    end

    // The last column of a line always sends the FSM back to LEAD.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (eol) begin
                state_d = StLead;
            end else if (!is_inv) begin
                state_d = StTrack;
            end
        end
    end

    always_comb begin
        fill   = din;
        last_d = last_q;
        run_d  = run_q;
        unique case (state_q)
            StLead: begin
                if (!is_inv) begin
                    last_d = din;
                    run_d  = '0;
                end else begin
                    fill = FILL_DEFAULT;
                end
            end
            StTrack: begin
                if (!is_inv) begin
                    last_d = din;
                    run_d  = '0;
                end else if (run_q < RW'(MAX_RUN)) begin
                    fill  = last_q;
                    run_d = run_q + RW'(1);
                end else begin
                    fill = INVALID;
                end
            end
            default: fill = din;
        endcase
        if (eol) begin
            last_d = '0;
            run_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= '0;
            run_q      <= '0;
            cnt_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            col        <= '0;
            line_done  <= 1'b0;
        end else begin
            dout_valid <= accept;
            line_done  <= accept & eol;
            if (accept) begin
                last_q <= last_d;
                run_q  <= run_d;
                dout   <= fill;
                col    <= cnt_q;
                cnt_q  <= eol ? '0 : cnt_q + CWIDTH'(1);
            end
        end
    end

`ifdef HOLE_FILL_STATS_EN
    logic [HW-1:0] hole_acc_q;

    // hole_cnt publishes the completed line total, including its final pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            hole_acc_q <= '0;
            hole_cnt   <= '0;
        end else if (accept) begin
            if (eol) begin
                hole_cnt   <= hole_acc_q + HW'(is_inv);
                hole_acc_q <= '0;
            end else begin
                hole_acc_q <= hole_acc_q + HW'(is_inv);
            end
        end
    end
`endif

endmodule
